io_input_conditioner: RTL and testbench

//   Conditions raw board inputs (slide switches, push buttons) into the clean,

---
 rtl/io_input_conditioner.sv | 68 ++++++
 tb/tb_io_input_conditioner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/io_input_conditioner.sv
// Board input conditioner: polarity normalisation, 2-FF synchronizer and a
// per-bit debounce filter feeding the core's memory-mapped io_input_bus.
module io_input_conditioner #(
  parameter int unsigned NUM_SWITCHES      = 10,
  parameter int unsigned NUM_BUTTONS       = 4,
  parameter int unsigned IO_INPUT_BUS_LEN  = 14,
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_SWITCHES-1:0]     raw_switches,
  input  logic [NUM_BUTTONS-1:0]      raw_buttons,
  output logic [IO_INPUT_BUS_LEN-1:0] io_input_bus
);

  localparam int unsigned W  = IO_INPUT_BUS_LEN;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

  if (IO_INPUT_BUS_LEN != NUM_SWITCHES + NUM_BUTTONS) begin : g_bad_len
    $error("io_input_conditioner: IO_INPUT_BUS_LEN must equal NUM_SWITCHES+NUM_BUTTONS");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("io_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [W-1:0]  norm;
  logic [W-1:0]  sync1_q, sync2_q;
  logic [W-1:0]  stable_q, stable_d;
  logic [CW-1:0] cnt_q [W];
  logic [CW-1:0] cnt_d [W];

  // Buttons are flipped before synchronizing so every bus bit reads 1 = active.
  assign norm = {raw_buttons ^ {NUM_BUTTONS{BUTTON_ACTIVE_LOW}}, raw_switches};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < W; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= norm;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < W; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign io_input_bus = stable_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner with a 4-cycle debounce window.
module tb_io_input_conditioner;

  localparam int unsigned NS = 10;
  localparam int unsigned NB = 4;
  localparam int unsigned W  = 14;
  localparam int unsigned D  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NS-1:0] raw_switches;
  logic [NB-1:0] raw_buttons;
  logic [W-1:0]  io_input_bus;

  // hist[k] holds the normalised input sampled k+1 edges before the upcoming edge.
  logic [W-1:0] hist [D+1];
  logic [W-1:0] m_stable;
  logic [W-1:0] exp_q [$];
  int           total = 0;
  int           bad   = 0;
  string        tag;

  io_input_conditioner #(
    .NUM_SWITCHES      (NS),
    .NUM_BUTTONS       (NB),
    .IO_INPUT_BUS_LEN  (W),
    .DEBOUNCE_CYCLES   (D),
    .BUTTON_ACTIVE_LOW (1'b1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .raw_switches (raw_switches),
    .raw_buttons  (raw_buttons),
    .io_input_bus (io_input_bus)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string t, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", t, obs, exp, $time);
    end
  endtask

  // A bit flips once the previous D synchronized samples all disagree with it.
  task automatic step();
    logic [W-1:0] n;
    logic         all_diff;
    n = {raw_buttons ^ {NB{1'b1}}, raw_switches};
    if (reset) begin
      for (int k = 0; k <= D; k++) hist[k] = '0;
      m_stable = '0;
    end else begin
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= D; k++) if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) m_stable[b] = ~m_stable[b];
      end
      for (int k = D; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = n;
    end
    exp_q.push_back(m_stable);
    @(posedge clock);
    #1;
    check_val(tag, io_input_bus, exp_q.pop_front());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int k = 0; k <= D; k++) hist[k] = '0;
    m_stable     = '0;
    reset        = 1'b1;
    raw_switches = '0;
    raw_buttons  = 4'hF;

    tag = "reset";
    steps(2);
    reset = 1'b0;
    steps(8);
    check_val("reset_idle", io_input_bus, 14'h0000);

    tag = "latency";
    raw_switches[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 5) check_val("lat_edge5", {13'b0, io_input_bus[0]}, 14'h0000);
      if (i == 6) check_val("lat_edge6", {13'b0, io_input_bus[0]}, 14'h0001);
    end

    tag = "glitch3";
    raw_switches[3] = 1'b1;
    steps(3);
    raw_switches[3] = 1'b0;
    steps(8);
    check_val("glitch3_low", {13'b0, io_input_bus[3]}, 14'h0000);

    tag = "glitch4";
    raw_switches[3] = 1'b1;
    steps(4);
    raw_switches[3] = 1'b0;
    check_val("glitch4_pre", {13'b0, io_input_bus[3]}, 14'h0000);
    steps(2);
    check_val("glitch4_high", {13'b0, io_input_bus[3]}, 14'h0001);
    steps(10);
    check_val("glitch4_fall", {13'b0, io_input_bus[3]}, 14'h0000);

    tag = "button";
    raw_buttons[2] = 1'b0;
    steps(8);
    check_val("btn_press", io_input_bus, 14'h1001);
    raw_buttons[2] = 1'b1;
    steps(8);
    check_val("btn_release", io_input_bus, 14'h0001);

    tag = "simul";
    raw_switches = '1;
    raw_buttons  = '0;
    steps(8);
    check_val("simul_all", io_input_bus, 14'h3FFF);
    raw_switches[7] = 1'b0;
    steps(8);
    check_val("simul_bit7", io_input_bus, 14'h3F7F);
    raw_switches[7] = 1'b1;
    steps(8);

    tag = "idle";
    raw_switches = '0;
    raw_buttons  = 4'hF;
    steps(8);

    tag = "rst_mid";
    raw_switches[5] = 1'b1;
    steps(2);
    reset = 1'b1;
    step();
    check_val("rst_mid_clear", io_input_bus, 14'h0000);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 5) check_val("rst_edge5", {13'b0, io_input_bus[5]}, 14'h0000);
      if (i == 6) check_val("rst_edge6", {13'b0, io_input_bus[5]}, 14'h0001);
    end

    tag = "random";
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        raw_switches = NS'($urandom);
        raw_buttons  = NB'($urandom);
      end
      step();
    end
    raw_switches = 10'h2A5;
    raw_buttons  = 4'h6;
    steps(8);
    check_val("random_settle", io_input_bus, 14'h26A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
